// File: rtl/operand_feeder_pkg.sv
// Shared sizing and FSM encoding for the operand feeder and its systolic array neighbours.
package systolic_pkg;
   localparam int DATA_WIDTH = 32;
   localparam int N          = 3;
   localparam int M          = 3;
   localparam int IDX_W      = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } feeder_state_e;
endpackage

// File: rtl/operand_feeder_if.sv
// Host load channel of the operand feeder: valid/ready handshake carrying one matrix element.
interface operand_feeder_if #(
   parameter int DATA_WIDTH = systolic_pkg::DATA_WIDTH
);
   logic                  ld_valid;
   logic                  ld_ready;
   logic                  ld_sel;
   logic [1:0]            ld_row;
   logic [1:0]            ld_col;
   logic [DATA_WIDTH-1:0] ld_data;

   modport master (output ld_valid, ld_sel, ld_row, ld_col, ld_data, input ld_ready);
   modport slave  (input ld_valid, ld_sel, ld_row, ld_col, ld_data, output ld_ready);
endinterface

// File: rtl/operand_feeder_lane.sv
// One feeder lane: read pointer, exhausted flag and show-ahead head mux over N stored words.
// Head follows the pointer with zero latency; reads on an exhausted lane or outside RUN are ignored.
module feeder_lane #(
   parameter int DATA_WIDTH = 32,
   parameter int N          = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  run,
   input  logic                  read_en,
   input  logic [DATA_WIDTH-1:0] words [N],
   output logic [DATA_WIDTH-1:0] head,
   output logic                  exhausted_nxt
`ifdef FEEDER_OVERRUN_DET_EN
   ,
   output logic                  err
`endif
);
   localparam int              PTR_W   = $clog2(N + 1);
   localparam logic [PTR_W-1:0] PTR_END = PTR_W'(N);

   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic             exhausted;

   assign exhausted = (ptr_q == PTR_END);

   always_comb begin
      ptr_d = ptr_q;
      if (clr) begin
         ptr_d = '0;
      end else if (run && read_en && !exhausted) begin
         ptr_d = ptr_q + 1'b1;
      end
   end

   assign exhausted_nxt = (ptr_d == PTR_END);

`ifdef FEEDER_OVERRUN_DET_EN
   assign err = read_en && (!run || exhausted);
`endif

   // An exhausted pointer matches no word, so the head falls to zero on its own.
   always_comb begin
      head = '0;
      for (int k = 0; k < N; k++) begin
         if (run && (ptr_q == PTR_W'(k))) head = words[k];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ptr_q <= '0;
      else      ptr_q <= ptr_d;
   end
endmodule

// File: rtl/operand_feeder.sv
// Streams preloaded A rows and B columns into a systolic array, one show-ahead word per lane.
// Sticky overrun detection is compiled in only when FEEDER_OVERRUN_DET_EN is defined.
module operand_feeder #(
   parameter int DATA_WIDTH = systolic_pkg::DATA_WIDTH,
   parameter int N          = systolic_pkg::N,
   parameter int M          = systolic_pkg::M
) (
   input  logic                  clk,
   input  logic                  rst,
   operand_feeder_if.slave       ld,
   input  logic                  start,
   input  logic [N-1:0]          A_read_en,
   input  logic [M-1:0]          B_read_en,
   output logic [DATA_WIDTH-1:0] A_in,
   output logic [DATA_WIDTH-1:0] A_in_1,
   output logic [DATA_WIDTH-1:0] A_in_2,
   output logic [DATA_WIDTH-1:0] B_in,
   output logic [DATA_WIDTH-1:0] B_in_1,
   output logic [DATA_WIDTH-1:0] B_in_2,
   output logic                  finished,
   output logic                  overrun
);
   import systolic_pkg::*;

   feeder_state_e         state_q, state_d;
   logic                  finished_q, finished_d;
   logic [DATA_WIDTH-1:0] a_q    [N][N];
   logic [DATA_WIDTH-1:0] a_d    [N][N];
   logic [DATA_WIDTH-1:0] b_q    [N][M];
   logic [DATA_WIDTH-1:0] b_d    [N][M];
   logic [DATA_WIDTH-1:0] b_cols [M][N];
   logic [DATA_WIDTH-1:0] a_head [N];
   logic [DATA_WIDTH-1:0] b_head [M];
   logic [N-1:0]          a_exh_nxt;
   logic [M-1:0]          b_exh_nxt;
   logic                  run, ld_ready, ld_acc, ld_in_range, ld_wr, start_acc;
`ifdef FEEDER_OVERRUN_DET_EN
   logic [N-1:0]          a_err;
   logic [M-1:0]          b_err;
   logic                  overrun_q, overrun_d;
`endif

   assign run         = (state_q == RUN);
   assign ld_ready    = !run;
   assign ld.ld_ready = ld_ready;
   assign ld_acc      = ld.ld_valid && ld_ready;
   assign start_acc   = start && !run;
   assign ld_in_range = (int'(ld.ld_row) < N) &&
                        (ld.ld_sel ? (int'(ld.ld_col) < M) : (int'(ld.ld_col) < N));
   // Out-of-range loads are handshaken but leave storage and FSM untouched.
   assign ld_wr       = ld_acc && ld_in_range;

   always_comb begin
      a_d = a_q;
      b_d = b_q;
      if (ld_wr) begin
         if (ld.ld_sel) b_d[ld.ld_row][ld.ld_col] = ld.ld_data;
         else           a_d[ld.ld_row][ld.ld_col] = ld.ld_data;
      end
   end

   always_comb begin
      for (int j = 0; j < M; j++) begin
         for (int k = 0; k < N; k++) b_cols[j][k] = b_q[k][j];
      end
   end

   // RUN ends on the edge that consumes the last word, so finished rises right after it.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (&{a_exh_nxt, b_exh_nxt}) state_d = DONE;
         DONE:    if (start) state_d = RUN;
                  else if (ld_wr) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      finished_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         finished_q <= 1'b0;
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) a_q[i][j] <= '0;
            for (int j = 0; j < M; j++) b_q[i][j] <= '0;
         end
      end else begin
         state_q    <= state_d;
         finished_q <= finished_d;
         a_q        <= a_d;
         b_q        <= b_d;
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_a_lane
      feeder_lane #(.DATA_WIDTH(DATA_WIDTH), .N(N)) u_lane (
         .clk           (clk),
         .rst           (rst),
         .clr           (start_acc),
         .run           (run),
         .read_en       (A_read_en[i]),
         .words         (a_q[i]),
         .head          (a_head[i]),
         .exhausted_nxt (a_exh_nxt[i])
`ifdef FEEDER_OVERRUN_DET_EN
         ,
         .err           (a_err[i])
`endif
      );
   end

   for (genvar j = 0; j < M; j++) begin : g_b_lane
      feeder_lane #(.DATA_WIDTH(DATA_WIDTH), .N(N)) u_lane (
         .clk           (clk),
         .rst           (rst),
         .clr           (start_acc),
         .run           (run),
         .read_en       (B_read_en[j]),
         .words         (b_cols[j]),
         .head          (b_head[j]),
         .exhausted_nxt (b_exh_nxt[j])
`ifdef FEEDER_OVERRUN_DET_EN
         ,
         .err           (b_err[j])
`endif
      );
   end

`ifdef FEEDER_OVERRUN_DET_EN
   // A start that is taken wins over a same-cycle stray read.
   always_comb begin
      overrun_d = overrun_q;
      if (start_acc)             overrun_d = 1'b0;
      else if (|{a_err, b_err})  overrun_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) overrun_q <= 1'b0;
      else      overrun_q <= overrun_d;
   end

   assign overrun = overrun_q;
`else
   assign overrun = 1'b0;
`endif

   assign A_in     = a_head[0];
   assign A_in_1   = a_head[1];
   assign A_in_2   = a_head[2];
   assign B_in     = b_head[0];
   assign B_in_1   = b_head[1];
   assign B_in_2   = b_head[2];
   assign finished = finished_q;
endmodule

// File: tb/tb_operand_feeder.sv
// Directed plus random bench for operand_feeder against a queue-per-lane reference model.
module tb_operand_feeder;
   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  a_re, b_re;
   logic [31:0] a_in0, a_in1, a_in2, b_in0, b_in1, b_in2;
   logic        finished, overrun;

   operand_feeder_if #(.DATA_WIDTH(32)) ldif ();

   operand_feeder #(.DATA_WIDTH(32), .N(3), .M(3)) dut (
      .clk(clk), .rst(rst), .ld(ldif), .start(start),
      .A_read_en(a_re), .B_read_en(b_re),
      .A_in(a_in0), .A_in_1(a_in1), .A_in_2(a_in2),
      .B_in(b_in0), .B_in_1(b_in1), .B_in_2(b_in2),
      .finished(finished), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Reference model: stored matrices, the words still owed by each lane, and run/done/overrun flags.
   logic [31:0] ref_a [3][3];
   logic [31:0] ref_b [3][3];
   logic [31:0] qa [3][$];
   logic [31:0] qb [3][$];
   bit          m_run, m_done, m_ovr;
   int          total, bad;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_a(input int i);
      if (m_run && qa[i].size() > 0) return qa[i][0];
      return 32'd0;
   endfunction

   function automatic logic [31:0] exp_b(input int j);
      if (m_run && qb[j].size() > 0) return qb[j][0];
      return 32'd0;
   endfunction

   function automatic logic exp_ovr();
`ifdef FEEDER_OVERRUN_DET_EN
      return m_ovr;
`else
      return 1'b0;
`endif
   endfunction

   task automatic check_all(input string tag);
      chk({tag, " A_in"},     a_in0, exp_a(0));
      chk({tag, " A_in_1"},   a_in1, exp_a(1));
      chk({tag, " A_in_2"},   a_in2, exp_a(2));
      chk({tag, " B_in"},     b_in0, exp_b(0));
      chk({tag, " B_in_1"},   b_in1, exp_b(1));
      chk({tag, " B_in_2"},   b_in2, exp_b(2));
      chk({tag, " finished"}, 32'(finished), 32'(m_done));
      chk({tag, " ld_ready"}, 32'(ldif.ld_ready), 32'(!m_run));
      chk({tag, " overrun"},  32'(overrun), 32'(exp_ovr()));
   endtask

   task automatic model_reset();
      m_run = 0; m_done = 0; m_ovr = 0;
      for (int i = 0; i < 3; i++) begin
         qa[i].delete();
         qb[i].delete();
         for (int j = 0; j < 3; j++) begin
            ref_a[i][j] = '0;
            ref_b[i][j] = '0;
         end
      end
   endtask

   // Applies the effect of the next rising edge given the inputs currently driven.
   task automatic model_edge();
      bit ld_ok, st_acc, err, all_empty;
      ld_ok  = ldif.ld_valid && !m_run && (ldif.ld_row < 2'd3) && (ldif.ld_col < 2'd3);
      st_acc = start && !m_run;
      err    = 0;
      for (int i = 0; i < 3; i++) begin
         if (a_re[i] && (!m_run || qa[i].size() == 0)) err = 1;
         if (b_re[i] && (!m_run || qb[i].size() == 0)) err = 1;
      end
      if (m_run) begin
         for (int i = 0; i < 3; i++) begin
            if (a_re[i] && qa[i].size() > 0) void'(qa[i].pop_front());
            if (b_re[i] && qb[i].size() > 0) void'(qb[i].pop_front());
         end
      end
      if (ld_ok) begin
         if (ldif.ld_sel) ref_b[ldif.ld_row][ldif.ld_col] = ldif.ld_data;
         else             ref_a[ldif.ld_row][ldif.ld_col] = ldif.ld_data;
      end
      all_empty = 1;
      for (int i = 0; i < 3; i++) if (qa[i].size() != 0 || qb[i].size() != 0) all_empty = 0;
      if (st_acc) begin
         m_ovr = 0; m_run = 1; m_done = 0;
         for (int i = 0; i < 3; i++) begin
            qa[i].delete();
            qb[i].delete();
            for (int k = 0; k < 3; k++) begin
               qa[i].push_back(ref_a[i][k]);
               qb[i].push_back(ref_b[k][i]);
            end
         end
      end else begin
         if (err) m_ovr = 1;
         if (m_done && ld_ok) m_done = 0;
         else if (m_run && all_empty) begin
            m_run = 0; m_done = 1;
         end
      end
   endtask

   task automatic cyc(input bit st, input logic [2:0] are, input logic [2:0] bre, input bit lv,
                      input bit sel, input logic [1:0] row, input logic [1:0] col,
                      input logic [31:0] dat, input string tag);
      start = st; a_re = are; b_re = bre;
      ldif.ld_valid = lv; ldif.ld_sel = sel; ldif.ld_row = row; ldif.ld_col = col; ldif.ld_data = dat;
      model_edge();
      @(posedge clk);
      #1;
      start = 0; a_re = '0; b_re = '0; ldif.ld_valid = 0;
      check_all(tag);
   endtask

   task automatic rd(input logic [2:0] are, input logic [2:0] bre, input string tag);
      cyc(0, are, bre, 0, 0, 2'd0, 2'd0, 32'd0, tag);
   endtask

   task automatic load(input bit sel, input logic [1:0] row, input logic [1:0] col, input logic [31:0] dat);
      cyc(0, 3'b000, 3'b000, 1, sel, row, col, dat, "load");
   endtask

   task automatic run_basic(input string tag);
      cyc(1, 3'b000, 3'b000, 0, 0, 2'd0, 2'd0, 32'd0, {tag, " start"});
      chk({tag, " w0 A_in"}, a_in0, 32'd1);
      chk({tag, " w0 A_in_2"}, a_in2, 32'd7);
      chk({tag, " w0 B_in_1"}, b_in1, 32'd11);
      chk({tag, " w0 overrun"}, 32'(overrun), 32'd0);
      rd(3'b111, 3'b111, {tag, " r1"});
      chk({tag, " w1 A_in"}, a_in0, 32'd2);
      chk({tag, " w1 A_in_2"}, a_in2, 32'd8);
      chk({tag, " w1 B_in_1"}, b_in1, 32'd14);
      rd(3'b111, 3'b111, {tag, " r2"});
      chk({tag, " w2 A_in"}, a_in0, 32'd3);
      chk({tag, " w2 A_in_2"}, a_in2, 32'd9);
      chk({tag, " w2 B_in_1"}, b_in1, 32'd17);
      chk({tag, " w2 finished"}, 32'(finished), 32'd0);
      rd(3'b111, 3'b111, {tag, " r3"});
      chk({tag, " end finished"}, 32'(finished), 32'd1);
      chk({tag, " end A_in"}, a_in0, 32'd0);
   endtask

   initial begin
      logic [2:0] skew [5];
      skew[0] = 3'b001; skew[1] = 3'b011; skew[2] = 3'b111; skew[3] = 3'b110; skew[4] = 3'b100;
      total = 0; bad = 0;
      rst = 1; start = 0; a_re = '0; b_re = '0;
      ldif.ld_valid = 0; ldif.ld_sel = 0; ldif.ld_row = '0; ldif.ld_col = '0; ldif.ld_data = '0;
      model_reset();
      #1 rst = 0;
      #11 check_all("reset");
      @(negedge clk) rst = 1;
      @(posedge clk); #1;

      // A = 1..9, B = 10..18 row-major, then a full parallel stream.
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            load(0, 2'(r), 2'(c), 32'(r * 3 + c + 1));
            load(1, 2'(r), 2'(c), 32'(10 + r * 3 + c));
         end
      end
      run_basic("basic");

      // Extra read in DONE, then restream without reload: the overrun flag clears.
      rd(3'b001, 3'b000, "read in done");
      chk("read in done A_in", a_in0, 32'd0);
      run_basic("restream");

      // Skewed reads, with a load attempt held off while running.
      cyc(1, 3'b000, 3'b000, 0, 0, 2'd0, 2'd0, 32'd0, "skew start");
      for (int s = 0; s < 5; s++) begin
         chk("skew ld_ready", 32'(ldif.ld_ready), 32'd0);
         chk("skew finished early", 32'(finished), 32'd0);
         cyc(0, skew[s], skew[s], (s == 1), 0, 2'd0, 2'd0, 32'd99, "skew");
      end
      chk("skew finished", 32'(finished), 32'd1);

      // Row 0 read past its end while other lanes still run.
      cyc(1, 3'b000, 3'b000, 0, 0, 2'd0, 2'd0, 32'd0, "exh start");
      chk("held-off load A_in", a_in0, 32'd1);
      for (int s = 0; s < 3; s++) rd(3'b001, 3'b000, "row0 drain");
      rd(3'b001, 3'b000, "row0 over");
      chk("row0 over A_in", a_in0, 32'd0);
      chk("row0 over A_in_1", a_in1, 32'd4);
      for (int s = 0; s < 3; s++) rd(3'b110, 3'b111, "exh finish");
      chk("exh finished", 32'(finished), 32'd1);

      // Out-of-range row is discarded: storage and DONE both unaffected.
      load(0, 2'd3, 2'd0, 32'd55);
      chk("bad row finished", 32'(finished), 32'd1);
      cyc(1, 3'b000, 3'b000, 0, 0, 2'd0, 2'd0, 32'd0, "bad row start");
      chk("bad row A_in", a_in0, 32'd1);
      chk("bad row A_in_1", a_in1, 32'd4);
      rd(3'b111, 3'b111, "bad row r1");
      rd(3'b111, 3'b111, "bad row r2");

      // Reset mid-run after the second read.
      #2 rst = 0;
      model_reset();
      #1;
      check_all("mid reset");
      chk("mid reset A_in", a_in0, 32'd0);
      chk("mid reset B_in_2", b_in2, 32'd0);
      @(negedge clk) rst = 1;
      @(posedge clk); #1;
      check_all("after reset");
      cyc(1, 3'b000, 3'b000, 1, 0, 2'd0, 2'd0, 32'h77, "start+load");
      chk("start+load A_in", a_in0, 32'h77);
      chk("start+load A_in_1", a_in1, 32'd0);
      for (int s = 0; s < 3; s++) rd(3'b111, 3'b111, "post reset");

      // Random traffic against the model.
      for (int n = 0; n < 600; n++) begin
         cyc(($urandom_range(0, 7) == 0),
             ($urandom_range(0, 1) == 1) ? 3'($urandom) : 3'b000,
             ($urandom_range(0, 1) == 1) ? 3'($urandom) : 3'b000,
             ($urandom_range(0, 3) == 0), 1'($urandom), 2'($urandom), 2'($urandom),
             $urandom, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
